// File: rtl/ff_bank_pkg.sv
// Shared types and constants for the configurable flip-flop bank.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam int POL_HOLD = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;

endpackage

// File: rtl/ff_cell.sv
// Combinational next-state and SR-invalid detection for one flip-flop channel.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter int POLICY = POL_HOLD
) (
  input  logic  q,
  input  logic  a,
  input  logic  b,
  input  mode_e mode,
  output logic  q_nxt,
  output logic  inv
);

  always_comb begin
    q_nxt = q;
    inv   = 1'b0;
    unique case (mode)
      MODE_SR: begin
        unique case ({a, b})
          2'b00: q_nxt = q;
          2'b01: q_nxt = 1'b0;
          2'b10: q_nxt = 1'b1;
          default: begin
            // Unknown policy values fall back to hold so SR 11 never yields X.
            inv = 1'b1;
            case (POLICY)
              POL_SET: q_nxt = 1'b1;
              POL_RST: q_nxt = 1'b0;
              default: q_nxt = q;
            endcase
          end
        endcase
      end
      MODE_JK: begin
        unique case ({a, b})
          2'b00:   q_nxt = q;
          2'b01:   q_nxt = 1'b0;
          2'b10:   q_nxt = 1'b1;
          default: q_nxt = ~q;
        endcase
      end
      MODE_D:  q_nxt = a;
      default: q_nxt = a ? ~q : q;
    endcase
  end

endmodule

// File: rtl/ff_bank_cfg.sv
// WIDTH-bit bank of mode-selectable flip-flops with SR-invalid event accounting.
module ff_bank_cfg
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 8,
  parameter int               POLICY  = POL_HOLD,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] invalid,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  logic [WIDTH-1:0] q_q, q_d, q_nxt;
  logic [WIDTH-1:0] inv_q, inv_d, inv_cell;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             ev;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(.POLICY(POLICY)) u_cell (
      .q     (q_q[i]),
      .a     (a[i]),
      .b     (b[i]),
      .mode  (mode_s),
      .q_nxt (q_nxt[i]),
      .inv   (inv_cell[i])
    );
  end

  always_comb begin
    q_d   = q_q;
    inv_d = '0;
    if (en) begin
      q_d   = q_nxt;
      inv_d = inv_cell;
    end
  end

  // Cells only flag invalid in SR mode, so any gated invalid bit is an event.
  assign ev = |inv_d;

  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (err_clr) begin
      cnt_d    = ev ? CNT_W'(1) : '0;
      sticky_d = ev;
    end else if (ev) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q      <= RST_VAL;
      inv_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      inv_q    <= inv_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign q          = q_q;
  assign q_bar      = ~q_q;
  assign invalid    = inv_q;
  assign err_cnt    = cnt_q;
  assign err_sticky = sticky_q;

endmodule
